// File: rtl/pll_lock_reset_seq_if.sv
// rtl/pll_lock_reset_seq_if.sv - lock input, reinit request and reset/status outputs of the sequencer
interface pll_lock_reset_seq_if;
  logic       pll_locked;
  logic       sw_reinit;
  logic       pll_rst;
  logic       sdram_reset_n;
  logic       sys_reset_n;
  logic [1:0] state;
  logic [7:0] lock_lost_cnt;

  modport master (
    input  pll_locked,
    input  sw_reinit,
    output pll_rst,
    output sdram_reset_n,
    output sys_reset_n,
    output state,
    output lock_lost_cnt
  );

  modport slave (
    output pll_locked,
    output sw_reinit,
    input  pll_rst,
    input  sdram_reset_n,
    input  sys_reset_n,
    input  state,
    input  lock_lost_cnt
  );
endinterface

// File: rtl/pll_lock_reset_seq.sv
// rtl/pll_lock_reset_seq.sv - PLL reset pulse, lock qualification and ordered SDRAM/system reset release
module pll_lock_reset_seq #(
  parameter int PLL_RST_CYCLES       = 32,
  parameter int LOCK_STABLE_CYCLES   = 1024,
  parameter int LOCK_TIMEOUT_CYCLES  = 65535,
  parameter int RELEASE_DELAY_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pll_lock_reset_seq_if.master bus
);

  localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CD = (LOCK_TIMEOUT_CYCLES > RELEASE_DELAY_CYCLES) ? LOCK_TIMEOUT_CYCLES : RELEASE_DELAY_CYCLES;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] PR_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_DELAY_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t        st;
  logic [CW-1:0] cnt;
  logic [CW-1:0] stab;
  logic [1:0]    sync;
  logic [2:0]    outs_q;
  logic [7:0]    lost_cnt;
  logic          lk_s;
  logic          lost;

  // {pll_rst, sdram_reset_n, sys_reset_n} for the state being entered
  function automatic logic [2:0] outs_for(input state_t s);
    logic [2:0] o;
    o = 3'b100;
    case (s)
      S_PLL_RST:   o = 3'b100;
      S_WAIT_LOCK: o = 3'b000;
      S_RELEASE:   o = 3'b010;
      S_RUN:       o = 3'b011;
    endcase
    return o;
  endfunction

  assign lk_s = sync[1];
  assign lost = !lk_s && (st == S_RELEASE || st == S_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st       <= S_PLL_RST;
      cnt      <= '0;
      stab     <= '0;
      sync     <= '0;
      outs_q   <= 3'b100;
      lost_cnt <= '0;
    end else begin
      sync <= {sync[0], bus.pll_locked};
      if (lost || bus.sw_reinit) begin
        st     <= S_PLL_RST;
        cnt    <= '0;
        stab   <= '0;
        outs_q <= outs_for(S_PLL_RST);
        if (lost && lost_cnt != 8'hff) begin
          lost_cnt <= lost_cnt + 8'd1;
        end
      end else begin
        case (st)
          S_PLL_RST: begin
            if (cnt == PR_LAST) begin
              st     <= S_WAIT_LOCK;
              cnt    <= '0;
              stab   <= '0;
              outs_q <= outs_for(S_WAIT_LOCK);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            // Lock qualification is checked first so it wins a tie with the timeout
            if (lk_s && stab == STB_LAST) begin
              st     <= S_RELEASE;
              cnt    <= '0;
              stab   <= '0;
              outs_q <= outs_for(S_RELEASE);
            end else if (cnt == TO_LAST) begin
              st     <= S_PLL_RST;
              cnt    <= '0;
              stab   <= '0;
              outs_q <= outs_for(S_PLL_RST);
            end else begin
              cnt  <= cnt + 1'b1;
              stab <= lk_s ? stab + 1'b1 : '0;
            end
          end
          S_RELEASE: begin
            if (cnt == REL_LAST) begin
              st     <= S_RUN;
              cnt    <= '0;
              stab   <= '0;
              outs_q <= outs_for(S_RUN);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_RUN: begin
            cnt  <= '0;
            stab <= '0;
          end
        endcase
      end
    end
  end

  assign bus.pll_rst       = outs_q[2];
  assign bus.sdram_reset_n = outs_q[1];
  assign bus.sys_reset_n   = outs_q[0];
  assign bus.state         = st;
  assign bus.lock_lost_cnt = lost_cnt;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb/tb_pll_lock_reset_seq.sv - scoreboard bench for the PLL lock reset sequencer
module tb_pll_lock_reset_seq;

  localparam int P = 8;
  localparam int L = 20;
  localparam int T = 50;
  localparam int R = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  pll_lock_reset_seq_if bus ();

  pll_lock_reset_seq #(
    .PLL_RST_CYCLES      (P),
    .LOCK_STABLE_CYCLES  (L),
    .LOCK_TIMEOUT_CYCLES (T),
    .RELEASE_DELAY_CYCLES(R)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.master)
  );

  typedef struct {
    int cyc;
    int st;
    int pr;
    int sd;
    int sy;
    int llc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int c, input int s, input int pr, input int sd, input int sy, input int llc);
    ev_t e;
    e.cyc = c; e.st = s; e.pr = pr; e.sd = sd; e.sy = sy; e.llc = llc;
    exp_q.push_back(e);
  endtask

  function automatic void chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endfunction

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every change of the observable outputs is one scoreboard event
  initial begin
    logic [12:0] prev;
    logic [12:0] cur;
    logic [12:0] want;
    ev_t e;
    prev = {2'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    forever begin
      @(negedge clk);
      cur = {bus.state, bus.pll_rst, bus.sdram_reset_n, bus.sys_reset_n, bus.lock_lost_cnt};
      checks++;
      if (bus.sys_reset_n && !bus.sdram_reset_n) begin
        errors++;
        $display("FAIL sys_before_sdram cyc=%0d", cyc);
      end
      checks++;
      if (bus.pll_rst != (bus.state == 2'd0)) begin
        errors++;
        $display("FAIL pll_rst_state cyc=%0d pll_rst=%0b state=%0d", cyc, bus.pll_rst, bus.state);
      end
      if (cur != prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          want = {e.st[1:0], e.pr[0], e.sd[0], e.sy[0], e.llc[7:0]};
          if (cyc != e.cyc || cur != want) begin
            errors++;
            $display("FAIL event cyc=%0d got=%h required_cyc=%0d required=%h", cyc, cur, e.cyc, want);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic lose(input int c, input bit reinit, input int llc);
    wait_to(c);
    bus.pll_locked = 1'b0;
    expect_ev(c + 3, 0, 1, 0, 0, llc);
    expect_ev(c + 3 + P, 1, 0, 0, 0, llc);
    expect_ev(c + 3 + P + L, 2, 0, 1, 0, llc);
    expect_ev(c + 3 + P + L + R, 3, 0, 1, 1, llc);
    @(negedge clk);
    bus.pll_locked = 1'b1;
    if (reinit) begin
      @(negedge clk);
      bus.sw_reinit = 1'b1;
      @(negedge clk);
      bus.sw_reinit = 1'b0;
    end
  endtask

  initial begin
    int b, s, s2, c, llc, r, b2, w, g, x, we;
    bus.pll_locked = 1'b0;
    bus.sw_reinit  = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pll_rst", bus.pll_rst, 1);
    chk("rst_sdram", bus.sdram_reset_n, 0);
    chk("rst_sys", bus.sys_reset_n, 0);
    chk("rst_state", bus.state, 0);
    chk("rst_llc", bus.lock_lost_cnt, 0);

    // Nominal startup
    b = cyc;
    reset_n = 1'b1;
    expect_ev(b + P, 1, 0, 0, 0, 0);
    wait_to(b + 12);
    bus.pll_locked = 1'b1;
    expect_ev(b + 12 + 2 + L, 2, 0, 1, 0, 0);
    expect_ev(b + 12 + 2 + L + R, 3, 0, 1, 1, 0);

    // sw_reinit in RUN, then in RELEASE
    s = b + 45;
    wait_to(s);
    bus.sw_reinit = 1'b1;
    expect_ev(s + 1, 0, 1, 0, 0, 0);
    expect_ev(s + 1 + P, 1, 0, 0, 0, 0);
    expect_ev(s + 1 + P + L, 2, 0, 1, 0, 0);
    @(negedge clk);
    bus.sw_reinit = 1'b0;
    s2 = s + 1 + P + L + 2;
    wait_to(s2);
    bus.sw_reinit = 1'b1;
    expect_ev(s2 + 1, 0, 1, 0, 0, 0);
    expect_ev(s2 + 1 + P, 1, 0, 0, 0, 0);
    expect_ev(s2 + 1 + P + L, 2, 0, 1, 0, 0);
    expect_ev(s2 + 1 + P + L + R, 3, 0, 1, 1, 0);
    @(negedge clk);
    bus.sw_reinit = 1'b0;

    // Lock loss coinciding with sw_reinit counts once
    c = s2 + 1 + P + L + R + 5;
    lose(c, 1'b1, 1);
    llc = 1;

    // Repeated losses in RUN saturate the counter
    for (int i = 0; i < 300; i++) begin
      c = c + 40;
      llc = (llc < 255) ? llc + 1 : 255;
      lose(c, 1'b0, llc);
    end

    // Asynchronous reset from RUN
    r = c + 40;
    wait_to(r);
    expect_ev(r + 1, 0, 1, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_pll_rst", bus.pll_rst, 1);
    chk("async_sdram", bus.sdram_reset_n, 0);
    chk("async_sys", bus.sys_reset_n, 0);
    chk("async_state", bus.state, 0);
    chk("async_llc", bus.lock_lost_cnt, 0);
    bus.pll_locked = 1'b0;

    // Lock timeout retries the PLL reset
    wait_to(r + 2);
    b2 = cyc;
    reset_n = 1'b1;
    expect_ev(b2 + P, 1, 0, 0, 0, 0);
    expect_ev(b2 + P + T, 0, 1, 0, 0, 0);
    expect_ev(b2 + 2 * P + T, 1, 0, 0, 0, 0);

    // One-cycle lock glitch restarts qualification
    w = b2 + 2 * P + T;
    wait_to(w);
    bus.pll_locked = 1'b1;
    g = w + L - 3;
    expect_ev(g + 3 + L, 2, 0, 1, 0, 0);
    expect_ev(g + 3 + L + R, 3, 0, 1, 1, 0);
    wait_to(g);
    bus.pll_locked = 1'b0;
    @(negedge clk);
    bus.pll_locked = 1'b1;

    // Lock qualification and timeout on the same edge: lock wins
    x = g + 3 + L + R + 5;
    wait_to(x);
    bus.pll_locked = 1'b0;
    we = x + 3 + P;
    expect_ev(x + 3, 0, 1, 0, 0, 1);
    expect_ev(we, 1, 0, 0, 0, 1);
    expect_ev(we + T, 2, 0, 1, 0, 1);
    expect_ev(we + T + R, 3, 0, 1, 1, 1);
    wait_to(we + T - 2 - L);
    bus.pll_locked = 1'b1;
    wait_to(we + T + R + 10);

    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event required_cyc=%0d state=%0d got=none", e.cyc, e.st);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pll_lock_reset_seq.md
PLL_LOCK_RESET_SEQ -- requirements
Module: pll_lock_reset_seq

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 32: cycles pll_rst is held high per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before lock is accepted.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65535: cycles allowed in WAIT_LOCK before the PLL is reset again.
REQ-004 SHALL have parameter RELEASE_DELAY_CYCLES, default 16: cycles between sdram_reset_n release and sys_reset_n release.
REQ-005 SHALL have port clk, input, 1: free-running 50 MHz reference clock, the same source that feeds the PLL refclk; never a PLL output.
REQ-006 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port pll_locked, input, 1: PLL locked flag, asynchronous to clk.
REQ-008 SHALL have port sw_reinit, input, 1: synchronous single-cycle request to re-run the full sequence.
REQ-009 SHALL have port pll_rst, output, 1: active-high reset to the PLL rst input.
REQ-010 SHALL have port sdram_reset_n, output, 1: active-low reset for the SDRAM controller.
REQ-011 SHALL have port sys_reset_n, output, 1: active-low reset for the rest of the system.
REQ-012 SHALL have port state, output, 2: current state encoding: 0 PLL_RST, 1 WAIT_LOCK, 2 RELEASE, 3 RUN.
REQ-013 SHALL have port lock_lost_cnt, output, 8: saturating count of lock losses seen in RUN or RELEASE.

Function
REQ-014 SHALL synchronize pll_locked through a two-flop chain; only the synchronized value (lk_s) is used, adding 2 cycles of latency.
REQ-015 SHALL implement four states, with all outputs registered:
- PLL_RST: pll_rst=1, sdram_reset_n=0, sys_reset_n=0; move to WAIT_LOCK after PLL_RST_CYCLES cycles.
- WAIT_LOCK: pll_rst=0, both resets asserted.
  - Stable counter increments while lk_s=1 and clears to 0 on any lk_s=0.
  - Reaching LOCK_STABLE_CYCLES moves to RELEASE.
  - Timeout counter reaching LOCK_TIMEOUT_CYCLES moves to PLL_RST.
  - If both limits are reached in the same cycle, lock wins and the state moves to RELEASE.
- RELEASE: sdram_reset_n=1, sys_reset_n=0; move to RUN after RELEASE_DELAY_CYCLES cycles.
- RUN: both reset outputs 1, pll_rst=0.
REQ-016 In RELEASE or RUN, lk_s=0 SHALL move to PLL_RST on the next edge; both reset outputs SHALL go low that same edge; lock_lost_cnt SHALL increment, saturating at 255.
REQ-017 sw_reinit=1 in any state SHALL move to PLL_RST and restart the PLL_RST count; it SHALL NOT increment lock_lost_cnt.
REQ-018 If lock loss and sw_reinit occur in the same cycle, the transition SHALL be to PLL_RST and lock_lost_cnt SHALL increment once.
REQ-019 Every state entry SHALL clear the shared cycle counter; counters SHALL be sized by $clog2 of the largest parameter plus 1 and SHALL NOT wrap.
REQ-020 sys_reset_n SHALL never be 1 while sdram_reset_n is 0.
REQ-021 pll_rst SHALL be 1 only in PLL_RST.

Reset
REQ-022 reset_n=0 SHALL asynchronously force:
- state to PLL_RST;
- pll_rst=1, sdram_reset_n=0, sys_reset_n=0;
- lock_lost_cnt=0, all counters 0, sync flops 0.
REQ-023 Deassertion of reset_n SHALL start the PLL_RST count on the first following clk edge.
REQ-024 An assertion of reset_n mid-sequence SHALL have the same effect as a power-on reset, and lock_lost_cnt SHALL be cleared.

Verification
REQ-025 Nominal startup: release reset_n; raise pll_locked at cycle 100 and hold it.
- Required: pll_rst low at cycle 32.
- Required: sdram_reset_n rises about 1024+2 cycles after locked rises.
- Required: sys_reset_n rises 16 cycles after sdram_reset_n.
REQ-026 Glitchy lock: in WAIT_LOCK, drop pll_locked for 1 cycle at stable count 1000.
- Required: the stable counter restarts, and release is delayed by the full 1024 cycles.
REQ-027 Lock timeout: hold pll_locked=0.
- Required: state returns to PLL_RST after 65535 WAIT_LOCK cycles, and pll_rst pulses again for 32 cycles.
- Required: lock_lost_cnt stays 0.
REQ-028 Lock loss in RUN: drop pll_locked.
- Required: both resets low within 3 cycles, state=0, lock_lost_cnt=1.
- Drive 300 losses. Required: lock_lost_cnt saturates at 255.
REQ-029 sw_reinit pulse in RELEASE:
- Required: sdram_reset_n low on the next edge, pll_rst high for 32 cycles.
- Required: lock_lost_cnt unchanged.
REQ-030 reset_n asserted while in RUN: all outputs go to their reset values with no clk edge.
- At every cycle in all tests: sys_reset_n=1 with sdram_reset_n=0 never occurs.
